// File: rtl/julia_pkg.sv
// Shared types and default geometry for the pixel-job dispatcher.
package julia_pkg;

    localparam int unsigned NB_DEFAULT   = 4;
    localparam int unsigned XMAX_DEFAULT = 640;
    localparam int unsigned YMAX_DEFAULT = 480;
    localparam int unsigned COORD_W      = 16;
    localparam int unsigned ADDR_W       = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2,
        DONE     = 2'd3
    } dispatch_state_t;

    // Pointer width that stays legal for a single-core configuration.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping mod NB.
module rr_arbiter
    import julia_pkg::*;
#(
    parameter int unsigned NB = NB_DEFAULT,
    parameter int unsigned PW = ptr_width(NB)
) (
    input  logic [NB-1:0] req,
    input  logic [PW-1:0] ptr,
    output logic [NB-1:0] grant_c,
    output logic          valid_c
);

    int unsigned idx;

    always_comb begin
        grant_c = '0;
        valid_c = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NB; k++) begin
            idx = (32'(ptr) + k) % NB;
            if (!valid_c && req[idx[PW-1:0]]) begin
                grant_c[idx[PW-1:0]] = 1'b1;
                valid_c              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/job_dispatch.sv
// Hands out raster-ordered pixel jobs to NB cores, one launch per cycle at most.
module job_dispatch
    import julia_pkg::*;
#(
    parameter int unsigned NB   = NB_DEFAULT,
    parameter int unsigned XMAX = XMAX_DEFAULT,
    parameter int unsigned YMAX = YMAX_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                enable,
    input  logic [NB-1:0]       busy,
    output logic [NB-1:0]       start_core,
    output logic [COORD_W-1:0]  job_x,
    output logic [COORD_W-1:0]  job_y,
    output logic [ADDR_W-1:0]   job_address,
    output logic                active,
    output logic                frame_done
);

    localparam int unsigned     PW     = ptr_width(NB);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(XMAX - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(YMAX - 1);

    dispatch_state_t      state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [NB-1:0]        pend_q, pend_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;

    logic [NB-1:0]        start_core_d;
    logic [COORD_W-1:0]   job_x_d, job_y_d;
    logic [ADDR_W-1:0]    job_address_d;
    logic                 active_d, frame_done_d;

    logic [NB-1:0]        eligible_c;
    logic [NB-1:0]        grant_c;
    logic                 grant_valid_c;
    logic [PW-1:0]        grant_idx_c;
    logic [PW-1:0]        ptr_inc_c;

    // A core is free only once it is idle and has acknowledged its last launch.
    assign eligible_c = ~busy & ~pend_q;

    rr_arbiter #(
        .NB (NB),
        .PW (PW)
    ) u_arb (
        .req     (eligible_c),
        .ptr     (ptr_q),
        .grant_c (grant_c),
        .valid_c (grant_valid_c)
    );

    always_comb begin
        grant_idx_c = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (grant_c[i]) begin
                grant_idx_c = PW'(i);
            end
        end
        if (32'(grant_idx_c) == NB - 1) begin
            ptr_inc_c = '0;
        end else begin
            ptr_inc_c = grant_idx_c + PW'(1);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        ptr_d         = ptr_q;
        addr_d        = addr_q;
        pend_d        = pend_q & ~busy;
        start_core_d  = '0;
        job_x_d       = job_x;
        job_y_d       = job_y;
        job_address_d = job_address;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DISPATCH;
                    x_d     = '0;
                    y_d     = '0;
                    ptr_d   = '0;
                    addr_d  = '0;
                end
            end
            DISPATCH: begin
                if (enable && grant_valid_c) begin
                    start_core_d  = grant_c;
                    pend_d        = pend_d | grant_c;
                    job_x_d       = x_q;
                    job_y_d       = y_q;
                    job_address_d = addr_q;
                    addr_d        = addr_q + ADDR_W'(1);
                    ptr_d         = ptr_inc_c;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = DRAIN;
                        end else begin
                            y_d = y_q + COORD_W'(1);
                        end
                    end else begin
                        x_d = x_q + COORD_W'(1);
                    end
                end
            end
            DRAIN: begin
                if ((busy == '0) && (pend_q == '0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        active_d     = (state_d == DISPATCH) || (state_d == DRAIN);
        frame_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            ptr_q       <= '0;
            pend_q      <= '0;
            addr_q      <= '0;
            start_core  <= '0;
            job_x       <= '0;
            job_y       <= '0;
            job_address <= '0;
            active      <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            ptr_q       <= ptr_d;
            pend_q      <= pend_d;
            addr_q      <= addr_d;
            start_core  <= start_core_d;
            job_x       <= job_x_d;
            job_y       <= job_y_d;
            job_address <= job_address_d;
            active      <= active_d;
            frame_done  <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_job_dispatch.sv
// Scoreboard bench for job_dispatch with a simple core model and randomized timing.
module tb_job_dispatch;

    localparam int NB   = 4;
    localparam int XMAX = 4;
    localparam int YMAX = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          enable = 1'b1;
    logic [NB-1:0] busy;
    logic [NB-1:0] core_busy = '0;
    logic [NB-1:0] force_busy = '0;
    logic [NB-1:0] start_core;
    logic [15:0]   job_x, job_y;
    logic [31:0]   job_address;
    logic          active, frame_done;

    int total = 0;
    int bad   = 0;

    assign busy = core_busy | force_busy;

    always #5 clk = ~clk;

    job_dispatch #(.NB(NB), .XMAX(XMAX), .YMAX(YMAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .enable      (enable),
        .busy        (busy),
        .start_core  (start_core),
        .job_x       (job_x),
        .job_y       (job_y),
        .job_address (job_address),
        .active      (active),
        .frame_done  (frame_done)
    );

    typedef struct {
        int x;
        int y;
        int a;
        bit last;
    } px_t;

    px_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Core model: after a launch, optional start latency then a busy window.
    int dly_max = 0, dur_min = 1, dur_max = 4;
    int dly[NB];
    int cnt[NB];
    initial for (int i = 0; i < NB; i++) begin dly[i] = 0; cnt[i] = 0; end

    always @(negedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (start_core[i]) begin
                dly[i] = $urandom_range(dly_max, 0);
                cnt[i] = $urandom_range(dur_max, dur_min);
            end else if (dly[i] > 0) begin
                dly[i] = dly[i] - 1;
            end else if (cnt[i] > 0) begin
                cnt[i] = cnt[i] - 1;
            end
            core_busy[i] = (dly[i] == 0) && (cnt[i] != 0);
        end
    end

    // Reference model + monitor: rules applied to inputs seen at each edge.
    int            m_phase = 0;
    logic [NB-1:0] m_pend = '0;
    int            m_ptr = 0;
    int            m_jx = 0, m_jy = 0, m_ja = 0;
    logic [NB-1:0] exp_sc, b_s, elig, pend_next;
    logic          en_s, st_s, rst_s;
    int            g;
    px_t           item;

    always @(posedge clk) begin
        b_s = busy; en_s = enable; st_s = start; rst_s = rst;
        exp_sc = '0;
        if (rst_s) begin
            m_phase = 0; m_pend = '0; m_ptr = 0;
            m_jx = 0; m_jy = 0; m_ja = 0;
        end else begin
            elig      = ~b_s & ~m_pend;
            pend_next = m_pend & ~b_s;
            case (m_phase)
                0: if (st_s) begin m_phase = 1; m_ptr = 0; end
                1: if (en_s && elig != '0) begin
                    g = -1;
                    for (int k = 0; k < NB; k++)
                        if (g < 0 && elig[(m_ptr + k) % NB]) g = (m_ptr + k) % NB;
                    exp_sc[g]    = 1'b1;
                    pend_next[g] = 1'b1;
                    m_ptr        = (g + 1) % NB;
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL scoreboard: launch with empty job queue at %0t", $time);
                    end else begin
                        item = exp_q.pop_front();
                        m_jx = item.x; m_jy = item.y; m_ja = item.a;
                        if (item.last) m_phase = 2;
                    end
                end
                2: if (b_s == '0 && m_pend == '0) m_phase = 3;
                default: m_phase = 0;
            endcase
            m_pend = pend_next;
        end
        #1;
        chk("start_core", 32'(start_core), 32'(exp_sc));
        chk("job_x", 32'(job_x), m_jx);
        chk("job_y", 32'(job_y), m_jy);
        chk("job_address", job_address, m_ja);
        chk("active", 32'(active), 32'(m_phase == 1 || m_phase == 2));
        chk("frame_done", 32'(frame_done), 32'(m_phase == 3));
    end

    bit rnd_en = 1'b0;

    task automatic push_frame();
        for (int y = 0; y < YMAX; y++)
            for (int x = 0; x < XMAX; x++) begin
                px_t p;
                p.x = x; p.y = y; p.a = y * XMAX + x;
                p.last = (x == XMAX - 1) && (y == YMAX - 1);
                exp_q.push_back(p);
            end
    endtask

    task automatic do_start();
        start = 1'b1;
        push_frame();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            if (rnd_en) enable = ($urandom % 5) != 0;
            if (frame_done) seen = 1'b1;
            n++;
        end
        enable = 1'b1;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL frame_done_timeout: got none expected pulse within %0d cycles", budget);
        end
        @(negedge clk);
    endtask

    task automatic wait_launches(input int want, input int budget);
        int got = 0;
        int n = 0;
        while (got < want && n < budget) begin
            @(negedge clk);
            if (start_core != '0) got++;
            n++;
        end
        total++;
        if (got < want) begin
            bad++;
            $display("FAIL launch_timeout: got %0d launches expected %0d", got, want);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Free cores, fixed busy window: cores 0..3 then back to core 0 on row 1.
        dly_max = 0; dur_min = 3; dur_max = 3;
        do_start();
        wait_done(200);

        // Enable dropped mid-frame; a stray start is also ignored.
        dur_min = 1; dur_max = 5; dly_max = 2;
        do_start();
        wait_launches(2, 100);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("no_launch_while_disabled", 32'(start_core), 0);
        end
        enable = 1'b1;
        wait_done(200);

        // Busy held high after the final launch.
        dly_max = 0; dur_min = 1; dur_max = 2;
        do_start();
        wait_launches(8, 200);
        force_busy = '1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("drain_active", 32'(active), 1);
            chk("drain_no_done", 32'(frame_done), 0);
        end
        force_busy = '0;
        wait_done(4);
        chk("idle_after_done", 32'(active), 0);

        // Mid-frame reset, then a clean restart.
        dur_min = 1; dur_max = 3;
        do_start();
        wait_launches(3, 100);
        rst = 1'b1;
        exp_q.delete();
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start();
        wait_done(200);

        // Core 1 permanently busy during dispatch.
        force_busy = 4'b0010;
        do_start();
        wait_launches(8, 300);
        force_busy = '0;
        wait_done(100);

        // Randomized frames with jittery enable.
        rnd_en = 1'b1;
        for (int f = 0; f < 8; f++) begin
            dly_max = $urandom_range(2, 0);
            dur_min = 1;
            dur_max = $urandom_range(8, 1);
            do_start();
            wait_done(1000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
